// File: rtl/matmul_pkg.sv
// Shared definitions for the byte-stream matrix multiplier: FSM state codes,
// error byte, and derivation of accumulator width and bytes sent per element.
// No logic here; consumed by matmul_stream_engine and mac_unit.
package matmul_pkg;

    // Session FSM state codes.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RX_A    = 3'd1;
    localparam logic [2:0] ST_RX_B    = 3'd2;
    localparam logic [2:0] ST_MAC     = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_TX_WAIT = 3'd5;
    localparam logic [2:0] ST_ERR     = 3'd6;

    // Byte reported in place of a result when the size byte is out of range.
    localparam logic [7:0] ERR_CODE_DEF = 8'hEE;

    // A dot product of max_n unsigned dw-bit pairs needs 2*dw + clog2(max_n)
    // bits, so the accumulator can never overflow.
    function automatic int calc_accw(input int dw, input int max_n);
        return 2 * dw + $clog2(max_n);
    endfunction

    // Whole bytes needed to ship one accumulator value, zero-extended.
    function automatic int calc_acc_bytes(input int accw);
        return (accw + 7) / 8;
    endfunction

endpackage

// File: rtl/mac_unit.sv
// Sequential multiply-accumulate: acc += a*b on en, synchronous clear on clr.
// Latency: the running sum is registered; sum shows acc + a*b combinationally.
// No backpressure: the caller decides when to enable or clear.
module mac_unit
    import matmul_pkg::*;
#(
    parameter int DW   = 8,
    parameter int ACCW = calc_accw(8, 4)
) (
    input  logic            bclk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [ACCW-1:0] sum
);

    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] prod;

    // Full-width product; operands are unsigned so zero-extension is exact.
    assign prod = ACCW'(a) * ACCW'(b);

    // The value acc would take on this cycle's enable, also used by the
    // caller to capture the final dot product without an extra cycle.
    assign sum = acc + prod;

    // Accumulator register; clear wins over enable so the caller can close
    // one dot product and start the next from zero on the same edge.
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/matmul_stream_engine.sv
// Receives N, A and B over a byte stream, computes C = A*B with one MAC,
// streams each C element MSB-first. First tx_start N+1 cycles after last B byte.
// Transmit side waits on tx_busy; bytes arriving while not receiving are dropped.
module matmul_stream_engine
    import matmul_pkg::*;
#(
    parameter int         MAX_N    = 4,
    parameter int         DW       = 8,
    parameter logic [7:0] ERR_CODE = ERR_CODE_DEF
) (
    input  logic       bclk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       overrun
);

    localparam int ACCW      = calc_accw(DW, MAX_N);
    localparam int ACC_BYTES = calc_acc_bytes(ACCW);
    localparam int SHW       = ACC_BYTES * 8;
    // Counters i/j/k and the size itself must be able to hold MAX_N.
    localparam int CW        = $clog2(MAX_N + 1);
    // Linear index arithmetic must be able to hold MAX_N*MAX_N.
    localparam int NW        = $clog2(MAX_N * MAX_N + 1);
    // Storage address width; the arrays are sized to a power of two so any
    // address value is in range.
    localparam int AW        = (MAX_N > 1) ? $clog2(MAX_N * MAX_N) : 1;
    localparam int DEPTH     = 1 << AW;
    localparam int BW        = (ACC_BYTES > 1) ? $clog2(ACC_BYTES) : 1;

    logic [2:0]      state;
    logic [CW-1:0]   n;
    logic [CW-1:0]   i;
    logic [CW-1:0]   j;
    logic [CW-1:0]   k;
    logic [AW-1:0]   idx;
    logic [BW-1:0]   bcnt;
    logic [SHW-1:0]  sh;
    logic            tw_first;
    logic            err_tx;
    logic [7:0]      tx_hold;

    logic [DW-1:0]   mat_a [DEPTH];
    logic [DW-1:0]   mat_b [DEPTH];

    logic [NW-1:0]   nn;
    logic [NW-1:0]   a_lin;
    logic [NW-1:0]   b_lin;
    logic [AW-1:0]   a_addr;
    logic [AW-1:0]   b_addr;
    logic            size_ok;
    logic            idx_last;
    logic            k_last;
    logic            j_last;
    logic            i_last;
    logic            byte_last;
    logic            rx_drop;
    logic            mac_clr;
    logic            mac_en;
    logic [ACCW-1:0] acc_sum;
    logic [7:0]      cur_byte;

    // ------------------------------------------------------------------
    // Index and end-of-range decode
    // ------------------------------------------------------------------
    assign nn        = NW'(n) * NW'(n);
    assign a_lin     = NW'(i) * NW'(n) + NW'(k);
    assign b_lin     = NW'(k) * NW'(n) + NW'(j);
    assign a_addr    = AW'(a_lin);
    assign b_addr    = AW'(b_lin);

    assign size_ok   = (rx_data != 8'd0) && (32'(rx_data) <= 32'(MAX_N));
    assign idx_last  = (NW'(idx) == nn - NW'(1));
    assign k_last    = (k == n - CW'(1));
    assign j_last    = (j == n - CW'(1));
    assign i_last    = (i == n - CW'(1));
    assign byte_last = (bcnt == BW'(ACC_BYTES - 1));

    // Any state that is not waiting for input bytes loses them.
    assign rx_drop   = (state == ST_MAC) || (state == ST_SEND) ||
                       (state == ST_TX_WAIT) || (state == ST_ERR);

    // ------------------------------------------------------------------
    // Multiply-accumulate
    // ------------------------------------------------------------------
    // Clear when the operands are complete (fresh session) and when each dot
    // product closes, so every element starts from zero.
    assign mac_en  = (state == ST_MAC);
    assign mac_clr = ((state == ST_RX_B) && rx_valid && idx_last) ||
                     ((state == ST_MAC) && k_last);

    mac_unit #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .bclk (bclk),
        .rst  (rst),
        .clr  (mac_clr),
        .en   (mac_en),
        .a    (mat_a[a_addr]),
        .b    (mat_b[b_addr]),
        .sum  (acc_sum)
    );

    // ------------------------------------------------------------------
    // Transmit handshake and status outputs
    // ------------------------------------------------------------------
    assign cur_byte = (state == ST_ERR) ? ERR_CODE : sh[SHW-1 -: 8];
    assign tx_start = ((state == ST_SEND) || (state == ST_ERR)) && !tx_busy;
    // Show the new byte in the start cycle itself, otherwise hold the last
    // one so tx_data only ever changes together with tx_start.
    assign tx_data  = tx_start ? cur_byte : tx_hold;

    // done marks the cycle the transmitter releases after the final C byte;
    // busy drops in that same cycle so the next session can follow directly.
    assign done = (state == ST_TX_WAIT) && !tw_first && !tx_busy && !err_tx &&
                  byte_last && i_last && j_last;
    assign busy = (state != ST_IDLE) && !done;

    // Remember the byte handed to the transmitter.
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            tx_hold <= 8'd0;
        end else if (tx_start) begin
            tx_hold <= cur_byte;
        end
    end

    // Sticky flags: a good size byte clears both, a bad one raises err,
    // bytes arriving during compute/transmit raise overrun.
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            err     <= 1'b0;
            overrun <= 1'b0;
        end else if ((state == ST_IDLE) && rx_valid) begin
            if (size_ok) begin
                err     <= 1'b0;
                overrun <= 1'b0;
            end else begin
                err <= 1'b1;
            end
        end else if (rx_valid && rx_drop) begin
            overrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Operand storage (contents beyond N*N are never read)
    // ------------------------------------------------------------------
    // Capture A and B bytes in row-major order.
    always_ff @(posedge bclk) begin
        if ((state == ST_RX_A) && rx_valid) begin
            mat_a[idx] <= rx_data[DW-1:0];
        end
        if ((state == ST_RX_B) && rx_valid) begin
            mat_b[idx] <= rx_data[DW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Session FSM and counters
    // ------------------------------------------------------------------
    // Walks receive -> (MAC -> SEND/TX_WAIT per byte) per element -> IDLE.
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            n        <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            idx      <= '0;
            bcnt     <= '0;
            sh       <= '0;
            tw_first <= 1'b0;
            err_tx   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (size_ok) begin
                            n     <= CW'(rx_data);
                            idx   <= '0;
                            state <= ST_RX_A;
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_RX_A: begin
                    if (rx_valid) begin
                        if (idx_last) begin
                            idx   <= '0;
                            state <= ST_RX_B;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                ST_RX_B: begin
                    if (rx_valid) begin
                        if (idx_last) begin
                            idx   <= '0;
                            i     <= '0;
                            j     <= '0;
                            k     <= '0;
                            state <= ST_MAC;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                ST_MAC: begin
                    // The last product is folded in via sum, so the element
                    // is ready to ship right after its N-th MAC cycle.
                    if (k_last) begin
                        sh    <= SHW'(acc_sum);
                        bcnt  <= '0;
                        k     <= '0;
                        state <= ST_SEND;
                    end else begin
                        k <= k + CW'(1);
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tw_first <= 1'b1;
                        state    <= ST_TX_WAIT;
                    end
                end
                ST_ERR: begin
                    if (!tx_busy) begin
                        tw_first <= 1'b1;
                        err_tx   <= 1'b1;
                        state    <= ST_TX_WAIT;
                    end
                end
                ST_TX_WAIT: begin
                    // The transmitter may not raise tx_busy until the cycle
                    // after tx_start, so that first cycle is skipped.
                    if (tw_first) begin
                        tw_first <= 1'b0;
                    end else if (!tx_busy) begin
                        if (err_tx) begin
                            err_tx <= 1'b0;
                            state  <= ST_IDLE;
                        end else if (!byte_last) begin
                            bcnt  <= bcnt + BW'(1);
                            sh    <= sh << 8;
                            state <= ST_SEND;
                        end else if (i_last && j_last) begin
                            i     <= '0;
                            j     <= '0;
                            state <= ST_IDLE;
                        end else begin
                            if (j_last) begin
                                j <= '0;
                                i <= i + CW'(1);
                            end else begin
                                j <= j + CW'(1);
                            end
                            state <= ST_MAC;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Self-checking bench for matmul_stream_engine: directed and random sessions
// against a plain-arithmetic matrix product, with a busy-holding transmitter.
// Covers reset, errors, mid-session reset, overrun and long tx_busy.
module tb_matmul_stream_engine;

    localparam int MAX_N     = 4;
    localparam int DW        = 8;
    localparam int ACC_BYTES = 3;

    logic       bclk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       err;
    logic       overrun;

    matmul_stream_engine #(
        .MAX_N    (MAX_N),
        .DW       (DW),
        .ERR_CODE (8'hEE)
    ) dut (
        .bclk     (bclk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .overrun  (overrun)
    );

    int         checks     = 0;
    int         errors     = 0;
    int         cyc        = 0;
    int         busy_len   = 10;
    int         busy_cnt   = 0;
    int         start_viol = 0;
    int         stab_viol  = 0;
    logic [7:0] held       = 8'd0;
    logic [7:0] got_q[$];
    int         start_cyc_q[$];
    int         ma[16];
    int         mb[16];
    int         last_rx_cyc = 0;

    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    always @(posedge bclk) cyc <= cyc + 1;

    // Transmitter model: logs each started byte, then reports busy for
    // busy_len cycles. Flags starts while busy and tx_data changes while busy.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge bclk);
            if (tx_start === 1'b1) begin
                if (tx_busy !== 1'b0) start_viol++;
                got_q.push_back(tx_data);
                start_cyc_q.push_back(cyc);
                held     = tx_data;
                busy_cnt = busy_len;
            end else if (tx_busy === 1'b1 && tx_data !== held) begin
                stab_viol++;
            end
            @(posedge bclk);
            #1;
            if (busy_cnt > 0) begin
                tx_busy = 1'b1;
                busy_cnt--;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(2, 0)) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Full session: reference product, byte stream, latency, done/busy timing.
    task automatic run_session(input int n, input bit inject, input string tag);
        int exp_q[$];
        int c;
        int seen;
        int b_at;
        int tb_at;
        int sv0;
        int st0;
        sv0 = stab_viol;
        st0 = start_viol;
        seen = 0;
        b_at = 0;
        tb_at = 0;
        got_q.delete();
        start_cyc_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                c = 0;
                for (int k = 0; k < n; k++) c += ma[i*n+k] * mb[k*n+j];
                for (int b = ACC_BYTES - 1; b >= 0; b--) exp_q.push_back((c >> (8 * b)) & 255);
            end
        end
        send_byte(8'(n));
        chk({tag, "_err_clr"}, 32'(err), 0);
        chk({tag, "_ovr_clr"}, 32'(overrun), 0);
        chk({tag, "_busy_on"}, 32'(busy), 1);
        for (int x = 0; x < n * n; x++) send_byte(8'(ma[x]));
        for (int x = 0; x < n * n; x++) send_byte(8'(mb[x]));
        last_rx_cyc = cyc - 1;
        if (inject) begin
            repeat (n) tick();
            chk({tag, "_start_at_inject"}, 32'(tx_start), 1);
            rx_data  = 8'h5A;
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
        end
        for (int w = 0; w < 6000 && seen == 0; w++) begin
            @(negedge bclk);
            if (done === 1'b1) begin
                seen  = 1;
                b_at  = 32'(busy);
                tb_at = 32'(tx_busy);
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        if (seen == 1) begin
            chk({tag, "_busy_at_done"}, b_at, 0);
            chk({tag, "_txbusy_at_done"}, tb_at, 0);
            @(negedge bclk);
            chk({tag, "_done_1cyc"}, 32'(done), 0);
        end
        tick();
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int x = 0; x < exp_q.size() && x < got_q.size(); x++)
            chk($sformatf("%s_b%0d", tag, x), 32'(got_q[x]), exp_q[x]);
        if (start_cyc_q.size() > 0)
            chk({tag, "_latency"}, start_cyc_q[0] - last_rx_cyc, n + 1);
        chk({tag, "_overrun"}, 32'(overrun), 32'(inject));
        chk({tag, "_tx_stable"}, stab_viol - sv0, 0);
        chk({tag, "_no_start_busy"}, start_viol - st0, 0);
    endtask

    // Bad size byte: exactly one error byte, err set, busy released.
    task automatic run_bad_size(input logic [7:0] sz, input string tag);
        int idle;
        idle = 0;
        got_q.delete();
        send_byte(sz);
        chk({tag, "_err_set"}, 32'(err), 1);
        for (int w = 0; w < 500 && idle == 0; w++) begin
            @(negedge bclk);
            if (busy === 1'b0) idle = 1;
        end
        chk({tag, "_busy_off"}, idle, 1);
        repeat (3) tick();
        chk({tag, "_nbytes"}, got_q.size(), 1);
        if (got_q.size() > 0) chk({tag, "_code"}, 32'(got_q[0]), 32'h0EE);
        chk({tag, "_err_sticky"}, 32'(err), 1);
    endtask

    initial begin
        int n;
        int min_gap;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(posedge bclk);
        #1;
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        tick();

        // N=2 directed example.
        for (int x = 0; x < 4; x++) begin
            ma[x] = x + 1;
            mb[x] = x + 5;
        end
        run_session(2, 1'b0, "n2");
        if (got_q.size() == 12) begin
            chk("n2_c00_lsb", 32'(got_q[2]), 32'h13);
            chk("n2_c11_lsb", 32'(got_q[11]), 32'h32);
        end

        // Reset in the middle of receiving B aborts everything.
        send_byte(8'd3);
        for (int x = 0; x < 9; x++) send_byte(8'(x + 1));
        for (int x = 0; x < 4; x++) send_byte(8'(x + 2));
        chk("midrx_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrx_rst_tx_data", 32'(tx_data), 0);
        chk("midrx_rst_tx_start", 32'(tx_start), 0);
        chk("midrx_rst_busy", 32'(busy), 0);
        chk("midrx_rst_done", 32'(done), 0);
        chk("midrx_rst_err", 32'(err), 0);
        chk("midrx_rst_overrun", 32'(overrun), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        ma[0] = 3;
        mb[0] = 7;
        run_session(1, 1'b0, "n1_after_rst");
        if (got_q.size() == 3) chk("n1_after_rst_lit", 32'(got_q[2]), 32'h15);

        // Worst-case magnitudes.
        for (int x = 0; x < 16; x++) begin
            ma[x] = 255;
            mb[x] = 255;
        end
        run_session(4, 1'b0, "ff4");
        if (got_q.size() == 48) begin
            chk("ff4_lit0", 32'(got_q[45]), 32'h03);
            chk("ff4_lit1", 32'(got_q[46]), 32'hF8);
            chk("ff4_lit2", 32'(got_q[47]), 32'h04);
        end

        // Invalid sizes, then a valid session clears err.
        run_bad_size(8'h05, "bad05");
        run_bad_size(8'h00, "bad00");
        ma[0] = $urandom_range(255, 0);
        mb[0] = $urandom_range(255, 0);
        run_session(1, 1'b0, "n1_after_err");

        // Random sizes and contents.
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(MAX_N, 1);
            for (int x = 0; x < 16; x++) begin
                ma[x] = $urandom_range(255, 0);
                mb[x] = $urandom_range(255, 0);
            end
            run_session(n, 1'b0, $sformatf("rnd%0d", r));
        end

        // Stray byte in the first SEND cycle: dropped, overrun raised.
        for (int x = 0; x < 16; x++) begin
            ma[x] = $urandom_range(255, 0);
            mb[x] = $urandom_range(255, 0);
        end
        run_session(2, 1'b1, "inject");
        run_session(3, 1'b0, "after_inject");

        // Long transmitter busy period.
        busy_len = 50;
        ma[0] = $urandom_range(255, 0);
        mb[0] = $urandom_range(255, 0);
        run_session(1, 1'b0, "hold50");
        min_gap = 1000000;
        for (int x = 1; x < start_cyc_q.size(); x++)
            if (start_cyc_q[x] - start_cyc_q[x-1] < min_gap) min_gap = start_cyc_q[x] - start_cyc_q[x-1];
        chk("hold50_gap_ok", 32'(min_gap > busy_len), 1);
        busy_len = 10;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_stream_engine.md
# matmul_stream_engine

Parametrised byte-stream matrix multiplier that replaces the fixed 3x3 receive/compute/loop-back datapath. It sits between `uart_rx`/`uart_tx` in the `bclk` domain and runs one full session per request:

- receive matrix size N
- receive A and B row-major
- compute C = A·B with a single sequential MAC
- stream each C element out big-endian through the UART transmitter handshake

Any N from 1 to MAX_N is supported without re-synthesis.

## Interface
Parameters:
- MAX_N, 4, largest supported square dimension (≥1)
- DW, 8, element width in bits; elements are unsigned, one rx byte each (DW ≤ 8)
- ACCW, 2·DW+clog2(MAX_N), accumulator width (derived, not overridable)
- ACC_BYTES, ceil(ACCW/8), bytes transmitted per C element (derived)
- ERR_CODE, 8'hEE, byte sent when the size byte is invalid

Ports:
- bclk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_busy  in  1  transmitter busy
- tx_data  out  8  byte to transmit, stable while tx_busy is high
- tx_start  out  1  one-cycle transmit request
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last C byte has finished transmitting
- err  out  1  sticky; set on an invalid size byte, cleared by the next valid size byte
- overrun  out  1  sticky; set when rx_valid arrives outside IDLE/RX_A/RX_B, cleared by the next valid size byte

## Operation
- States: IDLE, RX_A, RX_B, MAC, SEND, TX_WAIT, ERR.
- IDLE: the first rx_valid byte is N.
  - 1 ≤ N ≤ MAX_N: clear err/overrun, clear the element counter, go to RX_A.
  - Otherwise: set err, go to ERR.
- ERR: send ERR_CODE once using the tx handshake, then return to IDLE.
- RX_A: each rx_valid writes A[idx], idx counting 0..N·N−1. After the N·N-th byte, clear idx and go to RX_B.
- RX_B: same as RX_A into B. After the last byte, set i=j=k=0, acc=0, go to MAC.
- Storage is MAX_N·MAX_N entries per matrix. Entries beyond N·N are don't-care.
- MAC: one product per cycle, acc ← acc + A[i][k]·B[k][j].
  - After k=N−1, latch acc into the shift register and go to SEND.
  - Arithmetic is unsigned, full ACCW width, no overflow possible.
- SEND: emits ACC_BYTES bytes, most-significant first, zero-extended.
- Element order is row-major over (i,j).
  - After the last byte of element (N−1,N−1): pulse done, go to IDLE.
  - Otherwise: advance (j, then i), clear acc and k, go to MAC.
- rx_valid during MAC/SEND/TX_WAIT/ERR: the byte is dropped and overrun is set.

## Timing
- Reset values: tx_data=0, tx_start=0, busy=0, done=0, err=0, overrun=0; state IDLE; all counters and acc zero.
- Reset mid-session aborts immediately. No partial output resumes.
- Transmit handshake:
  - tx_start pulses for exactly one cycle, only when tx_busy=0, with tx_data already valid that cycle.
  - TX_WAIT ignores tx_busy for the first cycle after tx_start, then waits for tx_busy=0 before the next byte.
  - tx_data holds its value until the next tx_start.
- Latency from the last B byte's rx_valid to the first tx_start is N+1 cycles.
- Per element: N MAC cycles plus ACC_BYTES transmit handshakes.
- done asserts on the cycle tx_busy falls after the final byte. busy falls on the same cycle.
- Size byte and rx_valid in the same cycle as done: not possible (IDLE is entered after done). rx_valid in IDLE on the cycle after done is accepted.

## Structure
- Shared package `matmul_pkg`: state enumeration, ERR_CODE, and the ACCW/ACC_BYTES derivation functions.
- One sub-module: `mac_unit` (registered DW×DW multiply-accumulate with clear and enable, ACCW-wide).
- Matrix storage is inferred register arrays inside the engine.

## Test plan
Defaults are MAX_N=4, DW=8, ACCW=18, ACC_BYTES=3. The tx_busy model holds high for 10 cycles per start.
- N=2, A=1,2,3,4, B=5,6,7,8 → bytes 00 00 13, 00 00 16, 00 00 2B, 00 00 32, then done.
- N=4, all A/B bytes FF → 16 elements, each 03 F8 04; no overflow.
- Size byte 05, then size byte 00 → ERR_CODE sent once each, err=1, busy returns to 0; a following valid N=1 clears err.
- Reset asserted midway through RX_B → all outputs return to reset values. Then N=1, A=03, B=07 → 00 00 15.
- Inject rx_valid during SEND → the byte is ignored, overrun=1, the output stream is unchanged. The next valid size byte clears overrun.
- Hold tx_busy high for 50 cycles → no second tx_start until tx_busy falls; tx_data is stable throughout.
